// File: rtl/ahb_input_stage_dmas1.sv
// AHB-Lite input stage for the DMA slave port (S1) of the DMA bus matrix.
// Passes address phases through when granted, otherwise holds and stalls the master until granted.
module ahb_input_stage_dmas1 (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSELS,
   input  logic [31:0] HADDRS,
   input  logic [1:0]  HTRANSS,
   input  logic        HWRITES,
   input  logic [2:0]  HSIZES,
   input  logic [2:0]  HBURSTS,
   input  logic [3:0]  HPROTS,
   input  logic        HMASTLOCKS,
   input  logic        HREADYS,
   input  logic        active_dec,
   input  logic        readyout_dec,
   input  logic [1:0]  resp_dec,
   output logic        sel_dec,
   output logic [21:0] decode_addr_dec,
   output logic [31:0] addr_dec,
   output logic [1:0]  trans_dec,
   output logic        write_dec,
   output logic [2:0]  size_dec,
   output logic [2:0]  burst_dec,
   output logic [3:0]  prot_dec,
   output logic        mastlock_dec,
   output logic        held_tran,
   output logic        HREADYOUTS,
   output logic [1:0]  HRESPS
);

   logic        pend_q, pend_d;
   logic        data_phase_q, data_phase_d;
   logic        hold_sel_q, hold_sel_d;
   logic [31:0] hold_addr_q, hold_addr_d;
   logic [1:0]  hold_trans_q, hold_trans_d;
   logic        hold_write_q, hold_write_d;
   logic [2:0]  hold_size_q, hold_size_d;
   logic [2:0]  hold_burst_q, hold_burst_d;
   logic [3:0]  hold_prot_q, hold_prot_d;
   logic        hold_mastlock_q, hold_mastlock_d;

   logic new_tran;
   logic load;
   logic accept;

   assign new_tran = HSELS & HTRANSS[1] & HREADYS;
   assign load     = new_tran & ~active_dec & ~pend_q;
   assign accept   = (new_tran & active_dec & ~pend_q) | (pend_q & active_dec & readyout_dec);

   always_comb begin
      pend_d          = pend_q;
      data_phase_d    = data_phase_q;
      hold_sel_d      = hold_sel_q;
      hold_addr_d     = hold_addr_q;
      hold_trans_d    = hold_trans_q;
      hold_write_d    = hold_write_q;
      hold_size_d     = hold_size_q;
      hold_burst_d    = hold_burst_q;
      hold_prot_d     = hold_prot_q;
      hold_mastlock_d = hold_mastlock_q;

      if (load) begin
         pend_d          = 1'b1;
         hold_sel_d      = HSELS;
         hold_addr_d     = HADDRS;
         hold_trans_d    = HTRANSS;
         hold_write_d    = HWRITES;
         hold_size_d     = HSIZES;
         hold_burst_d    = HBURSTS;
         hold_prot_d     = HPROTS;
         hold_mastlock_d = HMASTLOCKS;
      end else if (pend_q & active_dec & readyout_dec) begin
         pend_d = 1'b0;
      end

      // A completing data phase and a fresh accept on the same edge keep data_phase set.
      if (accept) begin
         data_phase_d = 1'b1;
      end else if (data_phase_q & readyout_dec) begin
         data_phase_d = 1'b0;
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         pend_q          <= 1'b0;
         data_phase_q    <= 1'b0;
         hold_sel_q      <= 1'b0;
         hold_addr_q     <= 32'h0;
         hold_trans_q    <= 2'b00;
         hold_write_q    <= 1'b0;
         hold_size_q     <= 3'b000;
         hold_burst_q    <= 3'b000;
         hold_prot_q     <= 4'h0;
         hold_mastlock_q <= 1'b0;
      end else begin
         pend_q          <= pend_d;
         data_phase_q    <= data_phase_d;
         hold_sel_q      <= hold_sel_d;
         hold_addr_q     <= hold_addr_d;
         hold_trans_q    <= hold_trans_d;
         hold_write_q    <= hold_write_d;
         hold_size_q     <= hold_size_d;
         hold_burst_q    <= hold_burst_d;
         hold_prot_q     <= hold_prot_d;
         hold_mastlock_q <= hold_mastlock_d;
      end
   end

   // The holding register only ever captures selected transfers, so sel_dec is forced high.
   assign sel_dec         = pend_q ? 1'b1            : HSELS;
   assign addr_dec        = pend_q ? hold_addr_q     : HADDRS;
   assign trans_dec       = pend_q ? hold_trans_q    : HTRANSS;
   assign write_dec       = pend_q ? hold_write_q    : HWRITES;
   assign size_dec        = pend_q ? hold_size_q     : HSIZES;
   assign burst_dec       = pend_q ? hold_burst_q    : HBURSTS;
   assign prot_dec        = pend_q ? hold_prot_q     : HPROTS;
   assign mastlock_dec    = pend_q ? hold_mastlock_q : HMASTLOCKS;
   assign decode_addr_dec = addr_dec[31:10];
   assign held_tran       = pend_q;

   assign HREADYOUTS = pend_q ? 1'b0 : (data_phase_q ? readyout_dec : 1'b1);
   assign HRESPS     = pend_q ? 2'b00 : (data_phase_q ? resp_dec : 2'b00);

endmodule

// File: doc/ahb_input_stage_dmas1.md
Name: ahb_input_stage_dmas1

Overview:
- AHB-Lite input stage for the DMA slave port (S1) of the DMA bus matrix.
- Sits directly upstream of the S1 decoder stage.
- Passes address-phase signals through when the target output stage is granted.
- Otherwise captures the transfer in a holding register, stalls the master, and re-presents the transfer once granted. Also forwards the data-phase response back to the master.

Parameters:
- none; all widths fixed by the AHB-Lite 32-bit bus matrix.

Ports:
- HCLK  in  1  AHB system clock
- HRESETn  in  1  reset; synchronous, active-low
- HSELS  in  1  slave select from the DMA master
- HADDRS  in  32  address
- HTRANSS  in  2  transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- HWRITES  in  1  write
- HSIZES  in  3  size
- HBURSTS  in  3  burst
- HPROTS  in  4  protection
- HMASTLOCKS  in  1  locked transfer
- HREADYS  in  1  bus HREADY seen by the master
- active_dec  in  1  decoder: target output stage grants this input
- readyout_dec  in  1  decoder: selected HREADYOUT
- resp_dec  in  2  decoder: selected HRESP
- sel_dec  out  1  select to decoder
- decode_addr_dec  out  22  address bits [31:10] to decoder
- addr_dec  out  32  full address to output stages
- trans_dec  out  2  HTRANS to decoder
- write_dec, size_dec, burst_dec, prot_dec, mastlock_dec  out  1/3/3/4/1  control to output stages
- held_tran  out  1  high while the holding register drives the outputs
- HREADYOUTS  out  1  HREADYOUT to master
- HRESPS  out  2  HRESP to master

Behaviour:
- State (all updated on posedge HCLK):
  - pend: holding register valid.
  - data_phase: a forwarded transfer is in its data phase.
  - hold_*: captured sel/addr/trans/write/size/burst/prot/mastlock.
- Reset (HRESETn=0 at posedge): pend=0, data_phase=0, all hold_* = 0.
  - After reset: HREADYOUTS=1, HRESPS=00, held_tran=0; outputs pass through the live inputs.
  - Reset mid-operation discards any held transfer with no response.
- new_tran = HSELS & HTRANSS[1] & HREADYS.
- Output mux:
  - pend=1: outputs come from hold_*; sel_dec=1; trans_dec=hold_trans, unmodified.
  - pend=0: outputs come from live inputs; sel_dec=HSELS.
  - decode_addr_dec = addr_dec[31:10] in both cases.
  - held_tran = pend.
- Load: new_tran & ~active_dec & ~pend -> next cycle pend=1 and capture all inputs. Zero-cycle latency into the register.
- Accept, pass-through: new_tran & active_dec & ~pend -> next cycle data_phase=1, pend stays 0.
- Accept, held: pend & active_dec & readyout_dec -> next cycle pend=0, data_phase=1.
  - Held transfers pay a 1-cycle minimum penalty after grant.
- Data-phase end: data_phase & readyout_dec & no accept that cycle -> next cycle data_phase=0.
  - A back-to-back accept keeps data_phase=1.
- IDLE/BUSY transfers and HSELS=0 are never held. They pass through only, with no data_phase set.
- HREADYOUTS:
  - pend=1 -> 0.
  - else data_phase=1 -> readyout_dec.
  - else -> 1 (zero-wait OKAY for idle).
- HRESPS:
  - pend=1 -> 00.
  - else data_phase=1 -> resp_dec.
  - else -> 00.
- ERROR: the two-cycle ERROR from resp_dec (cycle 1 readyout_dec=0, cycle 2 readyout_dec=1) is forwarded unchanged. A master IDLE on cycle 2 is passed through normally.
- Simultaneous data-phase completion (readyout_dec=1) and new_tran with ~active_dec: the old data phase ends and the load happens in the same edge.
- While pend=1, live inputs are ignored. The master is stalled via HREADYOUTS=0, so HREADYS=0 and no new_tran is possible.
- Locked sequences: hold_mastlock is forwarded unchanged. Arbitration is owned by the output stage.

Test Plan:
- Reset with HRESETn=0 for 2 cycles while HTRANSS=10 -> HREADYOUTS=1, HRESPS=00, held_tran=0, pend=0 after release.
- Pass-through: NONSEQ write to 0x2000_0010 with active_dec=1; slave inserts 1 wait -> sel_dec=1 same cycle, decode_addr_dec=22'h080000, HREADYOUTS=0 then 1, HRESPS=00.
- Hold: NONSEQ read to 0x4000_0008 with active_dec=0 for 3 cycles, then 1 with readyout_dec=1 -> held_tran=1 and HREADYOUTS=0 for 3 cycles, addr_dec=0x4000_0008 held stable, pend clears on the grant edge, data returns the following cycle.
- Back-to-back: 4-beat INCR4 burst with active_dec=1 and readyout_dec=1 throughout -> no stall, data_phase stays 1, trans_dec sequence 10,11,11,11.
- ERROR: resp_dec=01 with readyout_dec 0 then 1 -> HRESPS=01 for both cycles, HREADYOUTS=0 then 1. Master IDLE on cycle 2 -> data_phase=0 next cycle.
- Reset mid-hold: pend=1 when HRESETn goes 0 -> next edge pend=0, held_tran=0, HREADYOUTS=1.
